// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: round-robin arbiter for the register-file debug read port.
// Grants at most one requester per cycle and registers its read address.
// Returns the read data tagged with the requester index two cycles after
// the grant.
// Optional feature macro: RF_ARB_WB_BYPASS_EN. When it is defined, a
// same-cycle writeback to the address being read is forwarded into the
// response.
module rf_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ADDR_W-1:0]         rf_raddr,
  input  logic [DATA_W-1:0]         rf_rdata,
  input  logic                      wb_en,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  // Round-robin pointer and pipeline state.
  logic [ID_W-1:0]   r_ptr;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_b_valid;
  logic [ID_W-1:0]   r_b_id;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;

  logic [ADDR_W-1:0] w_addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0] w_grant;
  logic               w_any;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_next_ptr;
  logic [DATA_W-1:0]  w_cap_data;

  // Split the packed request addresses into one slice per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign w_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Search req upward from the pointer with wrap at NUM_REQ; first hit wins.
  always_comb begin : p_arb
    int v_idx;
    w_grant = '0;
    w_any   = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        v_idx = int'(r_ptr) + k;
        if (v_idx >= NUM_REQ) begin
          v_idx = v_idx - NUM_REQ;
        end
        if (!w_any && req[v_idx]) begin
          w_any          = 1'b1;
          w_win          = ID_W'(v_idx);
          w_grant[v_idx] = 1'b1;
        end
      end
    end
  end

  assign w_next_ptr = (w_win == LAST_ID) ? '0 : w_win + 1'b1;

`ifdef RF_ARB_WB_BYPASS_EN
  // Forward a write landing on the register being read this cycle.
  assign w_cap_data = (wb_en && (wb_addr == r_raddr)) ? wb_data : rf_rdata;
`else
  // Without forwarding the response carries the pre-write value.
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_en, wb_addr, wb_data};
  assign w_cap_data  = rf_rdata;
`endif

  // Stage A: advance the pointer and launch the winner's read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_raddr   <= '0;
      r_b_valid <= 1'b0;
      r_b_id    <= '0;
    end else begin
      r_b_valid <= w_any;
      if (w_any) begin
        r_ptr   <= w_next_ptr;
        r_raddr <= w_addr_arr[w_win];
        r_b_id  <= w_win;
      end
    end
  end

  // Stage B: capture the returned data and present the tagged response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= r_b_valid;
      if (r_b_valid) begin
        r_rsp_id   <= r_b_id;
        r_rsp_data <= w_cap_data;
      end
    end
  end

  assign grant     = w_grant;
  assign rf_raddr  = r_raddr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Testbench for rf_read_arbiter: a per-cycle vector table for the default
// 4-requester instance, plus a hand-written wrap sequence on a 3-requester
// instance. Honours RF_ARB_WB_BYPASS_EN for the collision vector.
module tb_rf_read_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] req_addr;
  logic [3:0] grant;
  logic [1:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [7:0] rsp_data;

  // Three-requester instance for the non-power-of-two wrap.
  logic       rst3;
  logic [2:0] req3;
  logic [5:0] req_addr3;
  logic [2:0] grant3;
  logic [1:0] rf_raddr3;
  logic [7:0] rf_rdata3;
  logic       rsp_valid3;
  logic [1:0] rsp_id3;
  logic [7:0] rsp_data3;

  logic [7:0] regs [4];

  int n_vec;
  int n_bad;

`ifdef RF_ARB_WB_BYPASS_EN
  localparam logic [7:0] BYP = 8'h77;
`else
  localparam logic [7:0] BYP = 8'h11;
`endif

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [7:0] addr;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic [3:0] g;
    logic [1:0] raddr;
    logic       v;
    logic       chk;
    logic [1:0] id;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [30];

  rf_read_arbiter #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .grant(grant),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  rf_read_arbiter #(.NUM_REQ(3), .ADDR_W(2), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .req_addr(req_addr3), .grant(grant3),
    .rf_raddr(rf_raddr3), .rf_rdata(rf_rdata3), .wb_en(1'b0),
    .wb_addr(2'd0), .wb_data(8'h00), .rsp_valid(rsp_valid3),
    .rsp_id(rsp_id3), .rsp_data(rsp_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipeline register file model: combinational read of rf_raddr.
  assign rf_rdata  = regs[rf_raddr];
  assign rf_rdata3 = 8'hC3;

  task automatic check(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    regs[0] = 8'hA0; regs[1] = 8'hB1; regs[2] = 8'h5A; regs[3] = 8'h11;
    rst = 1'b1; req = '0; req_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    rst3 = 1'b1; req3 = '0; req_addr3 = 6'b10_01_00;

    //            rst req   addr  wbe wba wbd    g     ra v  chk id data
    vecs[0]  = '{1'b1, 4'h0, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h0, 2'd0, 1'b0, 1'b1, 2'd0, 8'h00};
    vecs[1]  = '{1'b0, 4'h1, 8'h02, 1'b0, 2'd0, 8'h00, 4'h1, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[2]  = '{1'b0, 4'h0, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h0, 2'd2, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[3]  = '{1'b0, 4'h0, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h0, 2'd2, 1'b1, 1'b1, 2'd0, 8'h5A};
    vecs[4]  = '{1'b1, 4'hF, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h0, 2'd2, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[5]  = '{1'b0, 4'hF, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h1, 2'd0, 1'b0, 1'b1, 2'd0, 8'h00};
    vecs[6]  = '{1'b0, 4'hF, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h2, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[7]  = '{1'b0, 4'hF, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h4, 2'd1, 1'b1, 1'b1, 2'd0, 8'hA0};
    vecs[8]  = '{1'b0, 4'hF, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h8, 2'd2, 1'b1, 1'b1, 2'd1, 8'hB1};
    vecs[9]  = '{1'b0, 4'hF, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h1, 2'd3, 1'b1, 1'b1, 2'd2, 8'h5A};
    vecs[10] = '{1'b0, 4'hF, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h2, 2'd0, 1'b1, 1'b1, 2'd3, 8'h11};
    vecs[11] = '{1'b0, 4'hF, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h4, 2'd1, 1'b1, 1'b1, 2'd0, 8'hA0};
    vecs[12] = '{1'b0, 4'hF, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h8, 2'd2, 1'b1, 1'b1, 2'd1, 8'hB1};
    vecs[13] = '{1'b0, 4'h2, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h2, 2'd3, 1'b1, 1'b1, 2'd2, 8'h5A};
    vecs[14] = '{1'b0, 4'h3, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h1, 2'd1, 1'b1, 1'b1, 2'd3, 8'h11};
    vecs[15] = '{1'b0, 4'h3, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h2, 2'd0, 1'b1, 1'b1, 2'd1, 8'hB1};
    vecs[16] = '{1'b0, 4'h0, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h0, 2'd1, 1'b1, 1'b1, 2'd0, 8'hA0};
    vecs[17] = '{1'b0, 4'h0, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h0, 2'd1, 1'b1, 1'b1, 2'd1, 8'hB1};
    vecs[18] = '{1'b0, 4'h0, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h0, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[19] = '{1'b0, 4'hF, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h4, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[20] = '{1'b0, 4'h8, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h8, 2'd2, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[21] = '{1'b0, 4'h0, 8'hE4, 1'b1, 2'd3, 8'h77, 4'h0, 2'd3, 1'b1, 1'b1, 2'd2, 8'h5A};
    vecs[22] = '{1'b0, 4'h4, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h4, 2'd3, 1'b1, 1'b1, 2'd3, BYP};
    vecs[23] = '{1'b0, 4'h0, 8'hE4, 1'b1, 2'd1, 8'h33, 4'h0, 2'd2, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[24] = '{1'b0, 4'h0, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h0, 2'd2, 1'b1, 1'b1, 2'd2, 8'h5A};
    vecs[25] = '{1'b0, 4'h2, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h2, 2'd2, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[26] = '{1'b1, 4'hE, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h0, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[27] = '{1'b0, 4'hE, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h2, 2'd0, 1'b0, 1'b1, 2'd0, 8'h00};
    vecs[28] = '{1'b0, 4'h0, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h0, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[29] = '{1'b0, 4'h0, 8'hE4, 1'b0, 2'd0, 8'h00, 4'h0, 2'd1, 1'b1, 1'b1, 2'd1, 8'hB1};

    // Table: drive just after the rising edge, check on the falling edge.
    for (int r = 0; r < 30; r++) begin
      @(posedge clk);
      #1;
      rst      = vecs[r].rst;
      req      = vecs[r].req;
      req_addr = vecs[r].addr;
      wb_en    = vecs[r].wb_en;
      wb_addr  = vecs[r].wb_addr;
      wb_data  = vecs[r].wb_data;
      @(negedge clk);
      n_vec++;
      check("grant", r, 32'(grant), 32'(vecs[r].g));
      check("rf_raddr", r, 32'(rf_raddr), 32'(vecs[r].raddr));
      check("rsp_valid", r, 32'(rsp_valid), 32'(vecs[r].v));
      if (vecs[r].chk) begin
        check("rsp_id", r, 32'(rsp_id), 32'(vecs[r].id));
        check("rsp_data", r, 32'(rsp_data), 32'(vecs[r].data));
      end
      $display("vec %0d: rst=%0b req=%h grant=%h raddr=%0d rsp_v=%0b id=%0d data=%h",
               r, rst, req, grant, rf_raddr, rsp_valid, rsp_id, rsp_data);
    end

    // Three requesters all active: pointer must wrap at 3, not at 4.
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    req3 = 3'b111;
    for (int c = 0; c < 6; c++) begin
      logic [2:0] eg;
      eg = 3'b001 << (c % 3);
      @(negedge clk);
      n_vec++;
      check("grant3", 100 + c, 32'(grant3), 32'(eg));
      if (c >= 2) begin
        check("rsp_valid3", 100 + c, 32'(rsp_valid3), 32'd1);
        check("rsp_id3", 100 + c, 32'(rsp_id3), 32'((c - 2) % 3));
        check("rsp_data3", 100 + c, 32'(rsp_data3), 32'h0000_00C3);
        check("rf_raddr3", 100 + c, 32'(rf_raddr3), 32'((c - 1) % 3));
      end else begin
        check("rsp_valid3", 100 + c, 32'(rsp_valid3), 32'd0);
      end
      $display("wrap3 %0d: grant3=%b raddr3=%0d rsp_v=%0b id=%0d",
               c, grant3, rf_raddr3, rsp_valid3, rsp_id3);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_read_arbiter.md
# rf_read_arbiter

Shares the single register-file debug read port of the four-register, 8-bit simple pipeline among several requesters: the verification wrapper's refinement checker, a trace monitor, and a test-bench peek agent. Each cycle it grants at most one requester round-robin and drives the pipeline's read address. It captures the returned data and delivers it tagged with the requester index two cycles after the grant. Optionally, it forwards a same-cycle writeback so the response never shows a stale register value.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 2, register address width (the pipeline has 4 registers)
- DATA_W, 8, register data width
- ID_W, $clog2(NUM_REQ), requester index width

- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester read request; held until granted
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i belongs to req[i]
- grant  out  NUM_REQ  one-hot, combinational; accepts slice i this cycle
- rf_raddr  out  ADDR_W  registered read address to the pipeline debug read port
- rf_rdata  in  DATA_W  combinational read data from the pipeline for rf_raddr
- wb_en  in  1  pipeline register-file write this cycle
- wb_addr  in  ADDR_W  write address
- wb_data  in  DATA_W  write data
- rsp_valid  out  1  response valid, single-cycle pulse
- rsp_id  out  ID_W  index of the requester the response belongs to
- rsp_data  out  DATA_W  read data

## Operation
- Arbitration: round-robin pointer ptr (ID_W bits).
  - Search req starting at ptr, upward with wrap-around, and grant the first requester found.
  - After a grant to i, ptr becomes (i+1) mod NUM_REQ.
  - ptr does not change in cycles with no grant.
- Grant semantics: a requester sees grant[i] while req[i] is high and may drop or change req/addr on the following cycle. grant is never asserted for a requester whose req is low.
- Stage A (grant cycle t): latch the winner's address into rf_raddr and its index into the stage-B id. Set stage-B valid.
- Stage B (cycle t+1): rf_rdata is valid for rf_raddr. Capture the data into rsp_data, copy the id into rsp_id, and set rsp_valid.
- Throughput: one grant per cycle; back-to-back grants pipeline without bubbles.
- rf_raddr holds its last value when there is no grant.
- Responses return in grant order. There is no back-pressure on the response side.
- Reset values:
  - grant: 0 (all requests are ignored while rst is high)
  - rf_raddr: 0
  - rsp_valid: 0
  - rsp_id: 0
  - rsp_data: 0
  - ptr: 0
  - stage-B valid: 0
- Reset mid-operation: all in-flight reads are discarded and no response is emitted for them. The first grant possible is in the cycle after rst deasserts.
- NUM_REQ not a power of two: the pointer wraps at NUM_REQ, not at 2^ID_W.

## Timing
- Grant to rsp_valid: exactly 2 cycles (grant in t, rsp_valid high in t+2).
- grant is combinational from req and ptr. There is no combinational path from rf_rdata to any output.
- Simultaneous requests: exactly one grant. The others stay pending and are served in pointer order on later cycles.
- Worst-case wait with all requesters active: NUM_REQ-1 cycles.

## Configuration
- RF_ARB_WB_BYPASS_EN defined:
  - In stage B, if wb_en is high and wb_addr equals rf_raddr, rsp_data captures wb_data instead of rf_rdata.
  - The response therefore reflects the register value after that cycle's write.
- RF_ARB_WB_BYPASS_EN undefined:
  - rsp_data always captures rf_rdata, i.e. the pre-write value in a collision cycle.
  - The wb_en, wb_addr and wb_data inputs are ignored.

## Test plan
- Single request: after reset, req=0001 with addr0=2 and rf_rdata=0x5A for r2.
  - grant=0001 in cycle 1.
  - rf_raddr=2 in cycle 2.
  - rsp_valid=1, rsp_id=0, rsp_data=0x5A in cycle 3.
- Full contention: req=1111 held for 8 cycles.
  - Grants are 0001, 0010, 0100, 1000, 0001, ...
  - Responses arrive with ids 0,1,2,3,0,... two cycles behind the grants, with no gaps.
- Pointer skip: ptr=2 after a grant to 1, then req=0011.
  - Next grant goes to 0 (wrapping past the idle requesters 2 and 3), and ptr becomes 1.
- Bypass collision: read r3 (old value 0x11) while wb_en=1, wb_addr=3, wb_data=0x77 in the rf_raddr cycle.
  - With the macro: rsp_data=0x77.
  - Without the macro: rsp_data=0x11.
- Reset mid-flight: grant in cycle t, rst=1 in cycle t+1.
  - No rsp_valid in t+2.
  - All outputs are 0.
  - The first post-reset grant goes to the lowest-index active requester.
